// File: rtl/memreq_wb_bridge.sv
// memreq_wb_bridge: bridges a core req/resp memory port onto a Wishbone
// classic master. A small request FIFO decouples the core, each command is
// decoded once when it leaves the FIFO (lane select, write replication,
// alignment check), and the bus cycle is watched by an optional timeout.
module memreq_wb_bridge #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int REQ_FIFO_DEPTH  = 2,
   parameter int RESP_REGISTERED = 1,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   // core request port
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [1:0]              req_width,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   // core response port
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,
   // Wishbone classic master
   output logic                    wb_cyc,
   output logic                    wb_stb,
   output logic                    wb_we,
   output logic [DATA_WIDTH/8-1:0] wb_sel,
   output logic [ADDR_WIDTH-1:0]   wb_addr,
   output logic [DATA_WIDTH-1:0]   wb_wdata,
   input  logic [DATA_WIDTH-1:0]   wb_rdata,
   input  logic                    wb_ack,
   input  logic                    wb_err
);

   localparam int NB      = DATA_WIDTH / 8;
   localparam int LANE_W  = $clog2(NB);
   localparam int SH_W    = LANE_W + 3;
   localparam int PTR_W   = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(REQ_FIFO_DEPTH + 1);
   localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_ERR,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [1:0]            width;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                state_q, state_d;

   req_t                  fifo_mem_q [REQ_FIFO_DEPTH];
   req_t                  fifo_mem_d [REQ_FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic                  cmd_we_q, cmd_we_d;
   logic [1:0]            cmd_width_q, cmd_width_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [NB-1:0]         wb_sel_q, wb_sel_d;
   logic [DATA_WIDTH-1:0] wb_wdata_q, wb_wdata_d;

   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic                  fifo_full, fifo_empty;
   logic                  push, pop;
   req_t                  head;
   logic [LANE_W-1:0]     head_lane;
   logic                  head_bad;
   logic [NB-1:0]         head_sel;
   logic [DATA_WIDTH-1:0] head_wdata;

   logic                  timeout_hit;
   logic                  bus_fire;
   logic                  bus_err;
   logic [DATA_WIDTH-1:0] bus_rdata;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(REQ_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign fifo_full  = (count_q == CNT_W'(REQ_FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign req_ready  = ~rst & ~fifo_full;
   assign push       = req_valid & req_ready;
   assign pop        = (state_q == ST_IDLE) & ~fifo_empty;
   assign head       = fifo_mem_q[rd_ptr_q];
   assign head_lane  = head.addr[LANE_W-1:0];

   // Decode the FIFO head: alignment/width legality, lane select, write replication.
   // NOTE: every signal assigned here gets a value on every path, otherwise a latch would be inferred.
   always_comb begin
      logic [NB-1:0] sel_base;
      head_bad   = 1'b0;
      sel_base   = '0;
      head_wdata = head.wdata;
      unique case (head.width)
         2'b00: begin
            sel_base   = NB'(1'b1);
            head_wdata = {NB{head.wdata[7:0]}};
         end
         2'b01: begin
            head_bad   = head.addr[0];
            sel_base   = NB'(2'b11);
            head_wdata = {(NB/2){head.wdata[15:0]}};
         end
         2'b10: begin
            head_bad   = (head.addr[1:0] != 2'b00);
            sel_base   = NB'(4'hF);
            head_wdata = {(NB/4){head.wdata[31:0]}};
         end
         default: begin
            head_bad   = (head.addr[2:0] != 3'b000) || (DATA_WIDTH != 64);
            sel_base   = '1;
            head_wdata = head.wdata;
         end
      endcase
      head_sel = sel_base << head_lane;
   end

   // Bus completion: ack beats err beats timeout.
   always_comb begin
      logic [DATA_WIDTH-1:0] shifted;
      logic [SH_W-1:0]       rd_shift;
      timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_W'(TO_LAST));
      bus_fire    = (state_q == ST_BUS) && (wb_ack || wb_err || timeout_hit);
      bus_err     = !wb_ack && (wb_err || timeout_hit);
      rd_shift    = {cmd_addr_q[LANE_W-1:0], 3'b000};
      shifted     = wb_rdata >> rd_shift;
      bus_rdata   = '0;
      if (wb_ack && !cmd_we_q) begin
         unique case (cmd_width_q)
            2'b00:   bus_rdata = DATA_WIDTH'(shifted[7:0]);
            2'b01:   bus_rdata = DATA_WIDTH'(shifted[15:0]);
            2'b10:   bus_rdata = DATA_WIDTH'(shifted[31:0]);
            default: bus_rdata = shifted;
         endcase
      end
   end

   // Request FIFO next-state: storage, pointers and occupancy.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = '{we: req_we, width: req_width, addr: req_addr, wdata: req_wdata};
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Transfer FSM next-state, command capture, timeout and registered response.
   always_comb begin
      state_d      = state_q;
      cmd_we_d     = cmd_we_q;
      cmd_width_d  = cmd_width_q;
      cmd_addr_d   = cmd_addr_q;
      wb_sel_d     = wb_sel_q;
      wb_wdata_d   = wb_wdata_q;
      to_cnt_d     = to_cnt_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               cmd_we_d    = head.we;
               cmd_width_d = head.width;
               cmd_addr_d  = head.addr;
               wb_sel_d    = head_sel;
               wb_wdata_d  = head_wdata;
               to_cnt_d    = '0;
               state_d     = head_bad ? ST_ERR : ST_BUS;
            end
         end
         ST_BUS: begin
            if (bus_fire) begin
               state_d  = ST_DONE;
               to_cnt_d = '0;
               if (RESP_REGISTERED != 0) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = bus_err;
                  resp_rdata_d = bus_rdata;
               end
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_ERR: begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and datapath registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cmd_we_q     <= 1'b0;
         cmd_width_q  <= 2'b00;
         cmd_addr_q   <= '0;
         wb_sel_q     <= '0;
         wb_wdata_q   <= '0;
         to_cnt_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cmd_we_q     <= cmd_we_d;
         cmd_width_q  <= cmd_width_d;
         cmd_addr_q   <= cmd_addr_d;
         wb_sel_q     <= wb_sel_d;
         wb_wdata_q   <= wb_wdata_d;
         to_cnt_q     <= to_cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // FIFO storage.
   // NOTE: the storage array is not reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      fifo_mem_q <= fifo_mem_d;
   end

   // Wishbone outputs come straight from registers so they are stable through BUS.
   assign wb_cyc   = (state_q == ST_BUS);
   assign wb_stb   = wb_cyc;
   assign wb_we    = cmd_we_q;
   assign wb_sel   = wb_sel_q;
   assign wb_addr  = {cmd_addr_q[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
   assign wb_wdata = wb_wdata_q;

   // Response select: registered copy, or the live bus result when unregistered.
   always_comb begin
      resp_valid = resp_valid_q;
      resp_err   = resp_err_q;
      resp_rdata = resp_rdata_q;
      if ((RESP_REGISTERED == 0) && bus_fire) begin
         resp_valid = 1'b1;
         resp_err   = bus_err;
         resp_rdata = bus_rdata;
      end
      if (rst) begin
         resp_valid = 1'b0;
         resp_err   = 1'b0;
         resp_rdata = '0;
      end
   end

endmodule

// File: tb/tb_memreq_wb_bridge.sv
// Directed bench for memreq_wb_bridge (32-bit data, 2-entry FIFO,
// registered response, 8-cycle timeout). Wishbone slave is driven by hand.
module tb_memreq_wb_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_width;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_addr;
   logic [31:0] wb_wdata;
   logic [31:0] wb_rdata;
   logic        wb_ack;
   logic        wb_err;

   int   total = 0;
   int   bad   = 0;
   int   n_cyc;
   logic seen;

   always #5 clk = ~clk;

   memreq_wb_bridge #(
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .REQ_FIFO_DEPTH  (2),
      .RESP_REGISTERED (1),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_width  (req_width),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_sel     (wb_sel),
      .wb_addr    (wb_addr),
      .wb_wdata   (wb_wdata),
      .wb_rdata   (wb_rdata),
      .wb_ack     (wb_ack),
      .wb_err     (wb_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_we    = we;
      req_width = w;
      req_addr  = a;
      req_wdata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00;
      req_addr = '0; req_wdata = '0; wb_rdata = '0; wb_ack = 1'b0; wb_err = 1'b0;
      tick(); tick();
      check("rst_ready", req_ready, 0);
      check("rst_cyc", wb_cyc, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_sel", wb_sel, 0);
      check("rst_addr", wb_addr, 0);
      check("rst_wdata", wb_wdata, 0);
      rst = 1'b0; #1;
      check("ready_after_rst", req_ready, 1);

      // word read, ack at first opportunity: cyc at cycle 2, response at cycle 3
      drive(0, 2'b10, 32'h100, 0); tick();
      req_valid = 1'b0;
      check("rd_c1_cyc", wb_cyc, 0); tick();
      check("rd_cyc", wb_cyc, 1);
      check("rd_stb", wb_stb, 1);
      check("rd_sel", wb_sel, 4'hF);
      check("rd_addr", wb_addr, 32'h100);
      check("rd_we", wb_we, 0);
      check("rd_early_resp", resp_valid, 0);
      wb_ack = 1'b1; wb_rdata = 32'hDEADBEEF; tick();
      wb_ack = 1'b0;
      check("rd_resp_valid", resp_valid, 1);
      check("rd_rdata", resp_rdata, 32'hDEADBEEF);
      check("rd_err", resp_err, 0);
      check("rd_cyc_gap", wb_cyc, 0); tick();
      check("rd_resp_pulse", resp_valid, 0);

      // byte write to lane 3
      drive(1, 2'b00, 32'h103, 32'h5A); tick();
      req_valid = 1'b0; tick();
      check("wr_cyc", wb_cyc, 1);
      check("wr_we", wb_we, 1);
      check("wr_sel", wb_sel, 4'b1000);
      check("wr_wdata", wb_wdata, 32'h5A5A5A5A);
      check("wr_addr", wb_addr, 32'h100);
      wb_ack = 1'b1; tick();
      wb_ack = 1'b0;
      check("wr_resp_valid", resp_valid, 1);
      check("wr_err", resp_err, 0);
      check("wr_rdata", resp_rdata, 0); tick();

      // half read from upper half
      drive(0, 2'b01, 32'h202, 0); tick();
      req_valid = 1'b0; tick();
      check("hr_sel", wb_sel, 4'b1100);
      check("hr_addr", wb_addr, 32'h200);
      wb_ack = 1'b1; wb_rdata = 32'h1234ABCD; tick();
      wb_ack = 1'b0;
      check("hr_resp_valid", resp_valid, 1);
      check("hr_rdata", resp_rdata, 32'h00001234); tick();

      // byte read from lane 1
      drive(0, 2'b00, 32'h101, 0); tick();
      req_valid = 1'b0; tick();
      check("br_sel", wb_sel, 4'b0010);
      wb_ack = 1'b1; wb_rdata = 32'h1234ABCD; tick();
      wb_ack = 1'b0;
      check("br_rdata", resp_rdata, 32'h000000AB); tick();

      // misaligned word: no bus cycle, error two cycles after the pop
      drive(0, 2'b10, 32'h101, 0); tick();
      req_valid = 1'b0; tick();
      check("mis_c2_cyc", wb_cyc, 0);
      check("mis_c2_resp", resp_valid, 0); tick();
      check("mis_resp_valid", resp_valid, 1);
      check("mis_err", resp_err, 1);
      check("mis_rdata", resp_rdata, 0);
      check("mis_c3_cyc", wb_cyc, 0); tick();

      // doubleword width is illegal on a 32-bit bus
      drive(0, 2'b11, 32'h100, 0); tick();
      req_valid = 1'b0; tick();
      check("ill_cyc", wb_cyc, 0); tick();
      check("ill_resp_valid", resp_valid, 1);
      check("ill_err", resp_err, 1); tick();

      // wb_err response
      drive(0, 2'b10, 32'h500, 0); tick();
      req_valid = 1'b0; tick();
      wb_err = 1'b1; wb_rdata = 32'h77777777; tick();
      wb_err = 1'b0;
      check("be_resp_valid", resp_valid, 1);
      check("be_err", resp_err, 1);
      check("be_rdata", resp_rdata, 0); tick();

      // ack and err together: ack wins
      drive(0, 2'b10, 32'h504, 0); tick();
      req_valid = 1'b0; tick();
      wb_ack = 1'b1; wb_err = 1'b1; wb_rdata = 32'h0BADF00D; tick();
      wb_ack = 1'b0; wb_err = 1'b0;
      check("ae_err", resp_err, 0);
      check("ae_rdata", resp_rdata, 32'h0BADF00D); tick();

      // timeout: cyc high for exactly 8 cycles then error
      drive(0, 2'b10, 32'h300, 0); tick();
      req_valid = 1'b0; tick();
      n_cyc = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
         if (wb_cyc) n_cyc++;
         tick();
      end
      check("to_seen", seen, 1);
      check("to_cyc_count", n_cyc, 8);
      check("to_err", resp_err, 1);
      check("to_rdata", resp_rdata, 0); tick();

      // ack in the cycle the timeout expires: ack wins
      drive(0, 2'b10, 32'h304, 0); tick();
      req_valid = 1'b0; tick();
      repeat (7) tick();
      check("tack_cyc", wb_cyc, 1);
      wb_ack = 1'b1; wb_rdata = 32'hCAFEF00D; tick();
      wb_ack = 1'b0;
      check("tack_resp_valid", resp_valid, 1);
      check("tack_err", resp_err, 0);
      check("tack_rdata", resp_rdata, 32'hCAFEF00D); tick();

      // back-to-back reads with ack held off
      drive(0, 2'b10, 32'h400, 0); tick();
      drive(0, 2'b10, 32'h404, 0);
      check("b2b_ready_b", req_ready, 1); tick();
      drive(0, 2'b10, 32'h408, 0);
      check("b2b_ready_c", req_ready, 1);
      check("b2b_addr_a", wb_addr, 32'h400); tick();
      req_valid = 1'b0;
      check("b2b_full_ready", req_ready, 0); tick();
      wb_ack = 1'b1; wb_rdata = 32'h11111111; tick();
      wb_ack = 1'b0;
      check("b2b_resp_a", resp_valid, 1);
      check("b2b_rdata_a", resp_rdata, 32'h11111111); tick();
      check("b2b_cyc_gap", wb_cyc, 0); tick();
      check("b2b_cyc_b", wb_cyc, 1);
      check("b2b_addr_b", wb_addr, 32'h404);
      wb_ack = 1'b1; wb_rdata = 32'h22222222; tick();
      wb_ack = 1'b0;
      check("b2b_rdata_b", resp_rdata, 32'h22222222); tick();
      drive(0, 2'b10, 32'h40C, 0);
      check("b2b_ready_d", req_ready, 1); tick();
      req_valid = 1'b0;
      check("b2b_addr_c", wb_addr, 32'h408);
      check("b2b_cyc_c", wb_cyc, 1);

      // reset in the middle of the bus cycle, then a late ack
      rst = 1'b1; #1;
      check("mrst_resp_during", resp_valid, 0); tick();
      check("mrst_cyc_drop", wb_cyc, 0);
      wb_ack = 1'b1; wb_rdata = 32'h33333333; tick();
      rst = 1'b0; #1;
      check("mrst_no_resp", resp_valid, 0);
      check("mrst_ready", req_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         wb_ack = 1'b0;
         if (resp_valid || wb_cyc) seen = 1'b1;
      end
      check("mrst_quiet", seen, 0);

      // recovery read after reset
      drive(0, 2'b10, 32'h600, 0); tick();
      req_valid = 1'b0; tick();
      check("rec_cyc", wb_cyc, 1);
      check("rec_addr", wb_addr, 32'h600);
      wb_ack = 1'b1; wb_rdata = 32'h600DF00D; tick();
      wb_ack = 1'b0;
      check("rec_resp_valid", resp_valid, 1);
      check("rec_rdata", resp_rdata, 32'h600DF00D); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
